// File: rtl/ipod_pkg.sv
// Shared definitions for the flash-to-audio playback path.
//   FLASH_ADDR_W / FLASH_DATA_W / AUDIO_SAMPLE_W : default bus widths
//   AVALON_BYTEENABLE : full-word byte enable for every flash read
//   state_e    : sample-sequencer states in flash_sample_reader
//   rd_state_e : phases of the Avalon read master
package ipod_pkg;

    localparam int unsigned FLASH_ADDR_W   = 23;
    localparam int unsigned FLASH_DATA_W   = 32;
    localparam int unsigned AUDIO_SAMPLE_W = 16;

    localparam logic [3:0] AVALON_BYTEENABLE = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitData,
        StWaitTick0,
        StOut0,
        StWaitTick1,
        StOut1,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        RdIdle,
        RdReq,
        RdWait
    } rd_state_e;

endpackage

// File: rtl/avalon_read_master.sv
// Single-word Avalon-MM read master with read-data timeout.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req                   : one-cycle launch pulse; latches req_address, clears timeout_err
//   req_address           : word address to read
//   granted               : one-cycle pulse on the edge the read command is accepted
//   ack                   : one-cycle pulse on the edge word is captured (data or timeout)
//   word                  : captured read data (zero after a timeout)
//   timeout_err           : sticky, set when readdatavalid never arrived
//   flash_read/address    : Avalon command outputs
//   flash_waitrequest/readdata/readdatavalid : Avalon response inputs
module avalon_read_master
    import ipod_pkg::*;
#(
    parameter int unsigned ADDR_W      = FLASH_ADDR_W,
    parameter int unsigned DATA_W      = FLASH_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_address,
    output logic              granted,
    output logic              ack,
    output logic [DATA_W-1:0] word,
    output logic              timeout_err,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic [DATA_W-1:0] flash_readdata,
    input  logic              flash_readdatavalid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RdIdle;
            addr_q     <= '0;
            word_q     <= '0;
            count_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        count_d    = count_q;
        timeout_d  = timeout_q;
        case (rd_state_q)
            RdIdle: begin
                if (req) begin
                    addr_d     = req_address;
                    timeout_d  = 1'b0;
                    rd_state_d = RdReq;
                end
            end
            RdReq: begin
                if (!flash_waitrequest) begin
                    count_d    = '0;
                    rd_state_d = RdWait;
                end
            end
            RdWait: begin
                // Data arriving on the final counted cycle still wins over the timeout.
                if (flash_readdatavalid) begin
                    word_d     = flash_readdata;
                    rd_state_d = RdIdle;
                end else if (count_q == CNT_MAX) begin
                    word_d     = '0;
                    timeout_d  = 1'b1;
                    rd_state_d = RdIdle;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    assign flash_read    = (rd_state_q == RdReq);
    assign flash_address = addr_q;
    assign granted       = flash_read && !flash_waitrequest;
    assign ack           = (rd_state_q == RdWait) &&
                           (flash_readdatavalid || (count_q == CNT_MAX));
    assign word          = word_q;
    assign timeout_err   = timeout_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Reads one 32-bit word from flash and plays its two 16-bit samples out on
// successive sample ticks, then pulses finish back to the address handler.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, accepted only while idle
//   address, reverse    : word address and playback direction, latched on accepted start
//   sample_tick         : audio-rate strobe
//   flash_*             : Avalon-MM read master interface to the flash controller
//   audio_out           : current sample, held between updates
//   audio_valid         : one-cycle pulse when audio_out updates
//   finish              : one-cycle pulse after both samples are emitted
//   busy                : high whenever not idle
//   timeout_err         : sticky read-timeout flag, cleared by the next accepted start
module flash_sample_reader
    import ipod_pkg::*;
#(
    parameter int unsigned ADDR_W      = FLASH_ADDR_W,
    parameter int unsigned DATA_W      = FLASH_DATA_W,
    parameter int unsigned SAMPLE_W    = AUDIO_SAMPLE_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   address,
    input  logic                reverse,
    input  logic                sample_tick,
    output logic                flash_read,
    output logic [ADDR_W-1:0]   flash_address,
    output logic [3:0]          flash_byteenable,
    input  logic                flash_waitrequest,
    input  logic [DATA_W-1:0]   flash_readdata,
    input  logic                flash_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
    output logic                finish,
    output logic                busy,
    output logic                timeout_err
);

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                reverse_q, reverse_d;

    logic              rd_req;
    logic              rd_granted;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_word;

    logic [SAMPLE_W-1:0] lo_sample;
    logic [SAMPLE_W-1:0] hi_sample;

    avalon_read_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_read_master (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (rd_req),
        .req_address         (address),
        .granted             (rd_granted),
        .ack                 (rd_ack),
        .word                (rd_word),
        .timeout_err         (timeout_err),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid)
    );

    assign lo_sample = rd_word[SAMPLE_W-1:0];
    assign hi_sample = rd_word[DATA_W-1:SAMPLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            audio_q   <= '0;
            reverse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            audio_q   <= audio_d;
            reverse_q <= reverse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        audio_d   = audio_q;
        reverse_d = reverse_q;
        rd_req    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    rd_req    = 1'b1;
                    reverse_d = reverse;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (rd_granted) state_d = StWaitData;
            end
            StWaitData: begin
                if (rd_ack) state_d = StWaitTick0;
            end
            // Ticks are only honoured once resident in a tick-wait state, so a tick
            // coincident with the entering edge is deliberately dropped.
            StWaitTick0: begin
                if (sample_tick) begin
                    audio_d = reverse_q ? hi_sample : lo_sample;
                    state_d = StOut0;
                end
            end
            StOut0: state_d = StWaitTick1;
            StWaitTick1: begin
                if (sample_tick) begin
                    audio_d = reverse_q ? lo_sample : hi_sample;
                    state_d = StOut1;
                end
            end
            StOut1:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign audio_out        = audio_q;
    assign audio_valid      = (state_q == StOut0) || (state_q == StOut1);
    assign finish           = (state_q == StDone);
    assign busy             = (state_q != StIdle);
    assign flash_byteenable = AVALON_BYTEENABLE;

endmodule

// File: tb/tb_flash_sample_reader.sv
module tb_flash_sample_reader;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [22:0] address;
    logic        reverse;
    logic        sample_tick;
    logic        flash_read;
    logic [22:0] flash_address;
    logic [3:0]  flash_byteenable;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        finish;
    logic        busy;
    logic        timeout_err;

    flash_sample_reader #(
        .ADDR_W      (23),
        .DATA_W      (32),
        .SAMPLE_W    (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .address             (address),
        .reverse             (reverse),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_out           (audio_out),
        .audio_valid         (audio_valid),
        .finish              (finish),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Flash / tick environment controls
    int          stall_left      = 0;
    int          read_cycles     = 0;
    bit          respond         = 1'b1;
    bit          pending_valid   = 1'b0;
    bit          tick_with_valid = 1'b0;
    bit          force_tick      = 1'b0;
    int          tick_period     = 10;
    int          tick_cnt        = 0;
    logic [31:0] mem_word        = '0;

    // Scoreboard
    logic [15:0] exp_q[$];
    logic [22:0] exp_addr  = '0;
    int          av_count  = 0;
    int          fin_count = 0;

    typedef struct {
        logic [22:0] addr;
        logic        rev;
        logic [31:0] data;
        int          stall;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash responder and tick source; all inputs change on the falling edge.
    initial begin
        flash_waitrequest   = 1'b0;
        flash_readdatavalid = 1'b0;
        flash_readdata      = '0;
        sample_tick         = 1'b0;
        forever begin
            bit tick_now;
            @(negedge clk);
            tick_now            = 1'b0;
            flash_readdatavalid = 1'b0;
            if (pending_valid) begin
                flash_readdatavalid = 1'b1;
                flash_readdata      = mem_word;
                pending_valid       = 1'b0;
                if (tick_with_valid) tick_now = 1'b1;
            end
            if (flash_read) begin
                read_cycles++;
                if (stall_left > 0) begin
                    flash_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    flash_waitrequest = 1'b0;
                    if (respond) pending_valid = 1'b1;
                end
            end else begin
                flash_waitrequest = 1'b0;
            end
            if (tick_period != 0) begin
                tick_cnt++;
                if (tick_cnt >= tick_period) begin
                    tick_cnt = 0;
                    tick_now = 1'b1;
                end
            end
            if (force_tick) begin
                tick_now   = 1'b1;
                force_tick = 1'b0;
            end
            sample_tick = tick_now;
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (audio_valid) begin
                av_count++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL audio_valid: got unexpected pulse with audio_out %h", audio_out);
                end else begin
                    check("audio_out", {16'h0, audio_out}, {16'h0, exp_q.pop_front()});
                end
            end
            if (finish) fin_count++;
            if (flash_read) check("flash_address", {9'h0, flash_address}, {9'h0, exp_addr});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle before start", {31'h0, busy}, 32'h0);
    endtask

    task automatic launch(input logic [22:0] a, input logic r, input logic [31:0] d,
                          input int stall, input logic [15:0] e0, input logic [15:0] e1);
        wait_idle();
        exp_addr    = a;
        mem_word    = d;
        stall_left  = stall;
        read_cycles = 0;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        address = a;
        reverse = r;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        address = ~a;
        reverse = ~r;
        check("busy after start", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_finish(input int prev);
        int n = 0;
        while (fin_count == prev && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("finish count", fin_count - prev, 1);
        check("samples drained", exp_q.size(), 0);
    endtask

    initial begin
        int prev_fin;
        int prev_av;
        int n;

        vecs[0] = '{addr: 23'h000010, rev: 1'b0, data: 32'hBEEF_1234, stall: 0,
                    exp0: 16'h1234, exp1: 16'hBEEF};
        vecs[1] = '{addr: 23'h000010, rev: 1'b1, data: 32'hBEEF_1234, stall: 0,
                    exp0: 16'hBEEF, exp1: 16'h1234};
        vecs[2] = '{addr: 23'h7FFFFF, rev: 1'b0, data: 32'h8000_7FFF, stall: 5,
                    exp0: 16'h7FFF, exp1: 16'h8000};
        vecs[3] = '{addr: 23'h000000, rev: 1'b1, data: 32'hFFFF_0001, stall: 2,
                    exp0: 16'hFFFF, exp1: 16'h0001};
        vecs[4] = '{addr: 23'h2AAAAA, rev: 1'b0, data: 32'h0000_FFFF, stall: 0,
                    exp0: 16'hFFFF, exp1: 16'h0000};

        rst     = 1'b1;
        start   = 1'b0;
        address = '0;
        reverse = 1'b0;
        @(negedge clk);
        check("reset flash_read", {31'h0, flash_read}, 32'h0);
        check("reset flash_address", {9'h0, flash_address}, 32'h0);
        check("reset audio_out", {16'h0, audio_out}, 32'h0);
        check("reset audio_valid", {31'h0, audio_valid}, 32'h0);
        check("reset finish", {31'h0, finish}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset timeout_err", {31'h0, timeout_err}, 32'h0);
        check("byteenable", {28'h0, flash_byteenable}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven reads: forward, reverse, stalls, sign extremes
        for (int i = 0; i < 5; i++) begin
            prev_fin = fin_count;
            launch(vecs[i].addr, vecs[i].rev, vecs[i].data, vecs[i].stall,
                   vecs[i].exp0, vecs[i].exp1);
            wait_finish(prev_fin);
            check("read command cycles", read_cycles, vecs[i].stall + 1);
            check("no timeout", {31'h0, timeout_err}, 32'h0);
            check("idle after finish", {31'h0, busy}, 32'h0);
        end

        // Timeout: no readdatavalid, zero samples still played
        respond  = 1'b0;
        prev_fin = fin_count;
        launch(23'h001234, 1'b0, 32'hDEAD_BEEF, 0, 16'h0000, 16'h0000);
        n = 0;
        while (!timeout_err && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("timeout latency in range", {31'h0, (n >= TO + 1) && (n <= TO + 2)}, 32'h1);
        wait_finish(prev_fin);
        check("timeout sticky", {31'h0, timeout_err}, 32'h1);
        respond = 1'b1;

        // Next accepted start clears the flag
        prev_fin = fin_count;
        launch(23'h000400, 1'b0, 32'hCAFE_F00D, 0, 16'hF00D, 16'hCAFE);
        check("timeout cleared", {31'h0, timeout_err}, 32'h0);
        wait_finish(prev_fin);

        // start while busy ignored; tick coincident with WAIT_TICK0 entry dropped
        tick_period     = 0;
        tick_with_valid = 1'b1;
        prev_fin        = fin_count;
        prev_av         = av_count;
        launch(23'h000077, 1'b0, 32'h5555_AAAA, 3, 16'hAAAA, 16'h5555);
        address = 23'h155555;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("entry tick ignored", av_count - prev_av, 0);
        check("still waiting for tick", {31'h0, busy}, 32'h1);
        force_tick = 1'b1;
        repeat (5) @(negedge clk);
        check("first sample after tick", av_count - prev_av, 1);
        force_tick = 1'b1;
        wait_finish(prev_fin);
        repeat (5) @(negedge clk);
        check("busy start ignored", {31'h0, busy}, 32'h0);
        check("single read issued", read_cycles, 4);
        tick_with_valid = 1'b0;
        tick_period     = 10;

        // Asynchronous reset while waiting for the second tick
        prev_fin = fin_count;
        launch(23'h000321, 1'b0, 32'h1111_2222, 0, 16'h2222, 16'h1111);
        n = 0;
        while (!audio_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached first sample", {31'h0, audio_valid}, 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid reset busy", {31'h0, busy}, 32'h0);
        check("mid reset audio_out", {16'h0, audio_out}, 32'h0);
        check("mid reset flash_address", {9'h0, flash_address}, 32'h0);
        check("mid reset flash_read", {31'h0, flash_read}, 32'h0);
        check("mid reset finish", {31'h0, finish}, 32'h0);
        exp_q.delete();
        prev_av = av_count;
        @(negedge clk);
        rst           = 1'b0;
        pending_valid = 1'b1;
        repeat (30) @(negedge clk);
        check("no audio after reset", av_count - prev_av, 0);
        check("no finish after reset", fin_count - prev_fin, 0);
        check("idle after reset", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
